mp3_frame_mux: RTL and testbench

Byte-stream frame assembler for MPEG-1 Layer III frames: the transmit-side counterpart of the SD frame demultiplexer. It accepts the header word, an optional CRC16, side-information bytes and main-data bytes from separate ready/valid sources. It emits them in frame order as a single ready/valid byte stream toward the SD writer path. Segment lengths are derived from the header exactly as the receive side delineates them, so a frame written by this block re-parses identically.

---
 rtl/mp3_pkg.sv | 18 +
 rtl/mp3_frame_mux.sv | 202 ++++++++++++++++++++
 tb/tb_mp3_frame_mux.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp3_pkg.sv
// Shared MPEG-1 Layer III frame constants and the frame mux/demux FSM state type.
package mp3_pkg;

  localparam int unsigned HDR_LEN         = 4;
  localparam int unsigned CRC_LEN         = 2;
  localparam int unsigned SIDE_LEN_MONO   = 17;
  localparam int unsigned SIDE_LEN_STEREO = 32;
  localparam logic [1:0]  MODE_MONO       = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CRC,
    SIDE,
    MAIN
  } state_t;

endpackage

// File: rtl/mp3_frame_mux.sv
// mp3_frame_mux: assembles header, optional CRC16, side info and main data into
// one ready/valid byte stream in frame order.
// Optional build macro MP3_FRAME_MUX_COUNT_EN adds the frame_count output.
module mp3_frame_mux
  import mp3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] hdr_word,
  input  logic [10:0] hdr_frame_size,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  logic [15:0] crc_word,
  input  logic        crc_valid,
  output logic        crc_ready,
  input  logic [7:0]  si_data,
  input  logic        si_valid,
  output logic        si_ready,
  input  logic [7:0]  md_data,
  input  logic        md_valid,
  output logic        md_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        err
`ifdef MP3_FRAME_MUX_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  state_t      state, state_nxt;
  logic [10:0] cnt_q, cnt_nxt;
  logic [31:0] hdr_q;
  logic        crc_en_q;
  logic [10:0] side_len_q, main_len_q;

  logic [10:0] crc_len_w, side_len_w, overhead_w, main_len_w;
  logic        load, fire, accept, reject, frame_done;
  logic [7:0]  byte_nxt;

  assign load = !out_valid || out_ready;
  assign busy = (state != IDLE);

  // Segment lengths derived from the incoming header.
  always_comb begin
    crc_len_w  = hdr_word[16] ? 11'd0 : 11'(CRC_LEN);
    side_len_w = (hdr_word[7:6] == MODE_MONO) ? 11'(SIDE_LEN_MONO) : 11'(SIDE_LEN_STEREO);
    overhead_w = 11'(HDR_LEN) + crc_len_w + side_len_w;
    main_len_w = hdr_frame_size - overhead_w;
  end

  // Next state, source readies and the byte offered to the output register.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_q;
    hdr_ready  = 1'b0;
    crc_ready  = 1'b0;
    si_ready   = 1'b0;
    md_ready   = 1'b0;
    fire       = 1'b0;
    byte_nxt   = out_data;
    accept     = 1'b0;
    reject     = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) begin
          if (hdr_frame_size < overhead_w) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = HDR;
            cnt_nxt   = '0;
          end
        end
      end
      HDR: begin
        if (load) begin
          fire = 1'b1;
          case (cnt_q[1:0])
            2'd0:    byte_nxt = hdr_q[31:24];
            2'd1:    byte_nxt = hdr_q[23:16];
            2'd2:    byte_nxt = hdr_q[15:8];
            default: byte_nxt = hdr_q[7:0];
          endcase
          if (cnt_q == 11'(HDR_LEN - 1)) begin
            state_nxt = crc_en_q ? CRC : SIDE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 11'd1;
          end
        end
      end
      CRC: begin
        // The CRC word is held by its source until the low byte is taken.
        crc_ready = load && (cnt_q == 11'(CRC_LEN - 1));
        if (load && crc_valid) begin
          fire     = 1'b1;
          byte_nxt = (cnt_q == 11'd0) ? crc_word[15:8] : crc_word[7:0];
          if (cnt_q == 11'(CRC_LEN - 1)) begin
            state_nxt = SIDE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + 11'd1;
          end
        end
      end
      SIDE: begin
        si_ready = load;
        if (load && si_valid) begin
          fire     = 1'b1;
          byte_nxt = si_data;
          if (cnt_q == side_len_q - 11'd1) begin
            cnt_nxt = '0;
            if (main_len_q == 11'd0) begin
              state_nxt  = IDLE;
              frame_done = 1'b1;
            end else begin
              state_nxt = MAIN;
            end
          end else begin
            cnt_nxt = cnt_q + 11'd1;
          end
        end
      end
      MAIN: begin
        md_ready = load;
        if (load && md_valid) begin
          fire     = 1'b1;
          byte_nxt = md_data;
          if (cnt_q == main_len_q - 11'd1) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            frame_done = 1'b1;
          end else begin
            cnt_nxt = cnt_q + 11'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and segment byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Header latch, output register and reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q      <= '0;
      crc_en_q   <= 1'b0;
      side_len_q <= '0;
      main_len_q <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        hdr_q      <= hdr_word;
        crc_en_q   <= !hdr_word[16];
        side_len_q <= side_len_w;
        main_len_q <= main_len_w;
      end
      if (fire) begin
        out_data  <= byte_nxt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MP3_FRAME_MUX_COUNT_EN
  // Completed-frame counter, stepped when the final byte of a frame is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  logic unused_done;
  assign unused_done = frame_done;
`endif

endmodule

// File: tb/tb_mp3_frame_mux.sv
// Directed bench for mp3_frame_mux with a frame-level expected byte model.
module tb_mp3_frame_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hdr_word;
  logic [10:0] hdr_frame_size;
  logic        hdr_valid, hdr_ready;
  logic [15:0] crc_word;
  logic        crc_valid, crc_ready;
  logic [7:0]  si_data;
  logic        si_valid, si_ready;
  logic [7:0]  md_data;
  logic        md_valid, md_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic        busy, err;
`ifdef MP3_FRAME_MUX_COUNT_EN
  logic [15:0] frame_count;
`endif

  always #5 clk = ~clk;

  mp3_frame_mux dut (
    .clk(clk), .rst(rst),
    .hdr_word(hdr_word), .hdr_frame_size(hdr_frame_size),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .crc_word(crc_word), .crc_valid(crc_valid), .crc_ready(crc_ready),
    .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready),
    .md_data(md_data), .md_valid(md_valid), .md_ready(md_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err)
`ifdef MP3_FRAME_MUX_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, req);
    end
  endfunction

  // Source byte patterns, indexed by position in each source's stream.
  function automatic logic [7:0] si_byte(input int k);
    return 8'((k * 5 + 1) & 255);
  endfunction
  function automatic logic [7:0] md_byte(input int k);
    return 8'((k * 3 + 64) & 255);
  endfunction

  // Frame model: expected output bytes in order.
  logic [7:0] exp_q[$];
  int         si_base = 0, md_base = 0;
  int         fpos = 0;

  function automatic bit model_frame(input logic [31:0] w, input int sz, input logic [15:0] crc);
    int crc_n, side_n, ovh, main_n;
    crc_n  = w[16] ? 0 : 2;
    side_n = (w[7:6] == 2'd3) ? 17 : 32;
    ovh    = 4 + crc_n + side_n;
    if (sz < ovh) return 1'b0;
    main_n = sz - ovh;
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    if (crc_n == 2) begin
      exp_q.push_back(crc[15:8]);
      exp_q.push_back(crc[7:0]);
    end
    for (int k = 0; k < side_n; k++) exp_q.push_back(si_byte(si_base + k));
    for (int k = 0; k < main_n; k++) exp_q.push_back(md_byte(md_base + k));
    si_base += side_n;
    md_base += main_n;
    fpos = 0;
    return 1'b1;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Negedge monitor: handshake sampling and the output compare.
  bit         rst_q = 1'b1, hs_si = 1'b0, hs_md = 1'b0;
  int         crc_hs = 0, err_cnt = 0;
  int         start_cyc = 0, end_cyc = 0;
  bit         stall_prev = 1'b0;
  logic [7:0] held = '0;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    rst_q = rst;
    hs_si = !rst && si_valid && si_ready;
    hs_md = !rst && md_valid && md_ready;
    if (!rst && crc_valid && crc_ready) crc_hs++;
    if (!rst && err) err_cnt++;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) check("stall_hold", {24'd0, out_data}, {24'd0, held});
      if (out_valid && !out_ready) begin
        check("stall_no_src", {29'd0, crc_ready, si_ready, md_ready}, 32'd0);
        held       = out_data;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got byte %0h, expected no output", out_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("out_byte", {24'd0, out_data}, {24'd0, exp_b});
          if (fpos == 0) start_cyc = cyc;
          fpos++;
          if (exp_q.size() == 0) end_cyc = cyc;
        end
      end
    end
  end

  // Source and sink driver: always-valid sources stepping on each handshake.
  bit rand_ready = 1'b0;
  int si_idx = 0, md_idx = 0;

  initial begin
    si_valid  = 1'b1;
    md_valid  = 1'b1;
    crc_valid = 1'b1;
    si_data   = si_byte(0);
    md_data   = md_byte(0);
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst_q) begin
        si_idx = 0;
        md_idx = 0;
      end else begin
        if (hs_si) si_idx++;
        if (hs_md) md_idx++;
      end
      si_data   = si_byte(si_idx);
      md_data   = md_byte(md_idx);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  int hs_cyc = 0;

  task automatic send_hdr(input logic [31:0] w, input int sz, output bit ok);
    int n;
    n = 0;
    while (!hdr_ready && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) check("hdr_ready_timeout", 32'd0, 32'd1);
    ok             = model_frame(w, sz, crc_word);
    hdr_word       = w;
    hdr_frame_size = 11'(sz);
    hdr_valid      = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc    = cyc;
    hdr_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20000) check("frame_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit ok;
  int crc0, err0;

  initial begin
    rst            = 1'b1;
    hdr_word       = '0;
    hdr_frame_size = '0;
    hdr_valid      = 1'b0;
    crc_word       = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_hdr_ready", {31'd0, hdr_ready}, 32'd1);
    check("rst_src_ready", {29'd0, crc_ready, si_ready, md_ready}, 32'd0);
    check("rst_busy_err", {30'd0, busy, err}, 32'd0);
`ifdef MP3_FRAME_MUX_COUNT_EN
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Mono, no CRC, 417 bytes.
    send_hdr(32'hFFFB_90C0, 417, ok);
    check("f1_model_ok", {31'd0, ok}, 32'd1);
    check("f1_model_len", 32'(exp_q.size() + fpos), 32'd417);
    wait_done();
    check("f1_latency", 32'(start_cyc - hs_cyc), 32'd1);
    check("f1_contiguous", 32'(end_cyc - start_cyc), 32'd416);
    check("f1_busy_low", {31'd0, busy}, 32'd0);
    check("f1_hdr_ready", {31'd0, hdr_ready}, 32'd1);

    // Stereo with CRC, 100 bytes.
    crc_word = 16'hBEEF;
    crc0     = crc_hs;
    send_hdr(32'hFFFA_9000, 100, ok);
    check("f2_model_ok", {31'd0, ok}, 32'd1);
    check("f2_model_len", 32'(exp_q.size() + fpos), 32'd100);
    wait_done();
    check("f2_crc_once", 32'(crc_hs - crc0), 32'd1);
    check("f2_contiguous", 32'(end_cyc - start_cyc), 32'd99);
    check("f2_busy_low", {31'd0, busy}, 32'd0);

    // Mono frame again with random backpressure.
    rand_ready = 1'b1;
    send_hdr(32'hFFFB_90C0, 417, ok);
    wait_done();
    check("f3_done", 32'(fpos), 32'd417);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef MP3_FRAME_MUX_COUNT_EN
    check("fc_three", {16'd0, frame_count}, 32'd3);
`endif

    // Rejected header: 20 bytes against an overhead of 21.
    err0 = err_cnt;
    send_hdr(32'hFFFB_90C0, 20, ok);
    check("rej_model", {31'd0, ok}, 32'd0);
    check("rej_err_pulse", {31'd0, err}, 32'd1);
    check("rej_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("rej_err_clear", {31'd0, err}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("rej_err_once", 32'(err_cnt - err0), 32'd1);
    check("rej_no_valid", {31'd0, out_valid}, 32'd0);
`ifdef MP3_FRAME_MUX_COUNT_EN
    check("fc_after_reject", {16'd0, frame_count}, 32'd3);
`endif

    // Reset during main data.
    send_hdr(32'hFFFB_90C0, 417, ok);
    begin
      int n;
      n = 0;
      while (md_idx < md_base - 396 + 10 && n < 5000) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 5000) check("md10_timeout", 32'd0, 32'd1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_hdr_ready", {31'd0, hdr_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    si_base = 0;
    md_base = 0;
    rst     = 1'b0;
    @(posedge clk);
    #1;

    // Full frame after the abandoned one.
    send_hdr(32'hFFFB_90C0, 417, ok);
    check("f4_first_byte_model", {24'd0, exp_q[0]}, 32'hFF);
    check("f4_si0_model", {24'd0, exp_q[4]}, 32'h01);
    check("f4_md0_model", {24'd0, exp_q[21]}, 32'h40);
    check("f4_last_model", {24'd0, exp_q[416]}, 32'hE1);
    wait_done();
    check("f4_latency", 32'(start_cyc - hs_cyc), 32'd1);
    check("f4_contiguous", 32'(end_cyc - start_cyc), 32'd416);
    check("f4_hdr_ready", {31'd0, hdr_ready}, 32'd1);
`ifdef MP3_FRAME_MUX_COUNT_EN
    check("fc_after_rst", {16'd0, frame_count}, 32'd1);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
